// File: rtl/memory_request_responder_pkg.sv
// memory_request_responder_pkg: widths, opcode encodings and request classification.
package memory_request_responder_pkg;
    localparam int INSTR_W  = 6;
    localparam int RSV_ID_W = 4;
    localparam int DATA_W   = 32;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_NOP     = 6'd0;
    localparam logic [INSTR_W-1:0] I_LOAD    = 6'd1;
    localparam logic [INSTR_W-1:0] I_LOADF   = 6'd2;
    localparam logic [INSTR_W-1:0] I_LOADR   = 6'd3;
    localparam logic [INSTR_W-1:0] I_LOADRF  = 6'd4;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'd5;
    localparam logic [INSTR_W-1:0] I_LOADBF  = 6'd6;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'd7;
    localparam logic [INSTR_W-1:0] I_STOREF  = 6'd8;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'd9;
    localparam logic [INSTR_W-1:0] I_STORERF = 6'd10;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'd11;
    localparam logic [INSTR_W-1:0] I_STOREBF = 6'd12;
    localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'd13;
    localparam logic [INSTR_W-1:0] I_ADD     = 6'd14;

    typedef enum logic [2:0] {
        MRR_NONE, MRR_STORE, MRR_STOREB, MRR_OUTPUT, MRR_LOAD, MRR_LOADB
    } mrr_class_e;

    function automatic mrr_class_e mrr_classify(input logic [INSTR_W-1:0] op);
        case (op)
            I_STORE, I_STOREF, I_STORER, I_STORERF: return MRR_STORE;
            I_STOREB, I_STOREBF:                    return MRR_STOREB;
            I_OUTPUT:                               return MRR_OUTPUT;
            I_LOAD, I_LOADF, I_LOADR, I_LOADRF:     return MRR_LOAD;
            I_LOADB, I_LOADBF:                      return MRR_LOADB;
            default:                                return MRR_NONE;
        endcase
    endfunction
endpackage

// File: rtl/mrr_data_ram.sv
// mrr_data_ram: single-port synchronous-read RAM with full-word and byte-lane-0 write enables.
module mrr_data_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              we_b,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (we_b) mem[addr][7:0] <= wdata[7:0];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/memory_request_responder.sv
// memory_request_responder: in-order store/output/load responder with credit-based result FIFO.
// Define MRR_STATS_EN to add saturating per-class accept counters.
module memory_request_responder
    import memory_request_responder_pkg::*;
#(
    parameter int MEM_DEPTH_W  = 10,
    parameter int RESULT_DEPTH = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_valid,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [DATA_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    input  logic                out_ready
`ifdef MRR_STATS_EN
    ,
    output logic [31:0]         o_load_count,
    output logic [31:0]         o_store_count,
    output logic [31:0]         o_output_count
`endif
);
    localparam int CW = $clog2(RESULT_DEPTH + 1);
    localparam int PW = $clog2(RESULT_DEPTH);

    mrr_class_e          cls;
    logic                accept, pop, is_load;
    logic [CW-1:0]       count;
    logic [CW:0]         used;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                inflight, inflight_b;
    logic [RSV_ID_W-1:0] inflight_tag;
    logic [DATA_W-1:0]   rdata, load_data;
    logic [CDB_W-1:0]    fifo [RESULT_DEPTH];
    logic                unused_addr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(RESULT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cls         = mrr_classify(i_opcode);
    assign is_load     = cls == MRR_LOAD || cls == MRR_LOADB;
    assign o_cdb_valid = count != '0;
    assign pop         = o_cdb_valid && o_cdb_ready;
    // Credits count the in-flight RAM read so a push can never find the FIFO full.
    assign used        = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    assign i_ready     = nrst && !(out_valid && !out_ready) && (used < (CW+1)'(RESULT_DEPTH));
    assign accept      = i_valid && i_ready;
    assign o_cdb       = o_cdb_valid ? fifo[rd_ptr] : '0;
    assign load_data   = inflight_b ? {{(DATA_W-8){1'b0}}, rdata[7:0]} : rdata;
    assign unused_addr = ^i_address[DATA_W-1:MEM_DEPTH_W];

    mrr_data_ram #(.ADDR_W(MEM_DEPTH_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .addr  (i_address[MEM_DEPTH_W-1:0]),
        .wdata (i_data),
        .we    (accept && cls == MRR_STORE),
        .we_b  (accept && cls == MRR_STOREB),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (inflight) fifo[wr_ptr] <= {inflight_tag, load_data};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= 1'b0;
            inflight_b   <= 1'b0;
            inflight_tag <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            inflight     <= accept && is_load;
            inflight_b   <= cls == MRR_LOADB;
            inflight_tag <= i_rsv_id;
            count        <= count + CW'(inflight) - CW'(pop);
            if (inflight) wr_ptr <= bump(wr_ptr);
            if (pop) rd_ptr <= bump(rd_ptr);
            if (accept && cls == MRR_OUTPUT) begin
                out_valid <= 1'b1;
                out_data  <= i_data[7:0];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MRR_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_load_count   <= '0;
            o_store_count  <= '0;
            o_output_count <= '0;
        end else if (accept) begin
            if (is_load && o_load_count != '1) o_load_count <= o_load_count + 32'd1;
            if ((cls == MRR_STORE || cls == MRR_STOREB) && o_store_count != '1) o_store_count <= o_store_count + 32'd1;
            if (cls == MRR_OUTPUT && o_output_count != '1) o_output_count <= o_output_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_memory_request_responder.sv
// tb_memory_request_responder: directed vector table, reset sequence and randomized model check.
module tb_memory_request_responder;
    import memory_request_responder_pkg::*;

    logic                clk = 1'b0;
    logic                nrst = 1'b1;
    logic                i_valid = 1'b0;
    logic [INSTR_W-1:0]  i_opcode = '0;
    logic [RSV_ID_W-1:0] i_rsv_id = '0;
    logic [DATA_W-1:0]   i_address = '0;
    logic [DATA_W-1:0]   i_data = '0;
    logic                i_ready;
    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready = 1'b1;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_ready = 1'b1;
`ifdef MRR_STATS_EN
    logic [31:0]         o_load_count, o_store_count, o_output_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    memory_request_responder dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_valid     (i_valid),
        .i_opcode    (i_opcode),
        .i_rsv_id    (i_rsv_id),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .o_cdb       (o_cdb),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_ready (o_cdb_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
`ifdef MRR_STATS_EN
        ,
        .o_load_count   (o_load_count),
        .o_store_count  (o_store_count),
        .o_output_count (o_output_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [3:0]  id;
        logic [31:0] a;
        logic [31:0] d;
        logic        cr;
        logic        orr;
        logic        er;
        logic        ecv;
        logic [35:0] ecdb;
        logic        eov;
        logic [7:0]  eod;
    } vec_t;

    typedef struct {
        logic [35:0] cdb;
        int          at;
    } res_t;

    vec_t        tbl[$];
    res_t        q[$];
    logic [31:0] mram [1024];

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [3:0] id,
                                input logic [31:0] a, input logic [31:0] d, input logic cr,
                                input logic orr, input logic er, input logic ecv,
                                input logic [35:0] ecdb, input logic eov, input logic [7:0] eod);
        vec_t t;
        t.v = v; t.op = op; t.id = id; t.a = a; t.d = d; t.cr = cr; t.orr = orr;
        t.er = er; t.ecv = ecv; t.ecdb = ecdb; t.eov = eov; t.eod = eod;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] d, input logic cr, input logic orr);
        i_valid = v; i_opcode = op; i_rsv_id = id; i_address = a; i_data = d;
        o_cdb_ready = cr; out_ready = orr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        @(negedge clk);
        #2 nrst = 1'b1;
        step();
    endtask

    initial begin
        int cyc;
        int n_ld, n_st, n_out;
        logic m_ov;
        logic [7:0] m_od;
        // Reset values while nrst is held low.
        #2 nrst = 1'b0;
        #10;
        chk("rst_ready", i_ready, 0);
        chk("rst_cdb_valid", o_cdb_valid, 0);
        chk("rst_cdb", o_cdb, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        #11 nrst = 1'b1;
        step();

        tbl.push_back(mk(1, I_STORE,  3, 32'h10, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,   5, 32'h10, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'h5DEADBEEF, 0, 0));
        tbl.push_back(mk(1, I_STOREB, 1, 32'h10, 32'h000000AA, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOADB,  6, 32'h10, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,   7, 32'h10, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'h6000000AA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'h7DEADBEAA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,   8, 32'h10, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,   9, 32'h10, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,  10, 32'h10, 0, 0, 1, 0, 1, 36'h8DEADBEAA, 0, 0));
        tbl.push_back(mk(1, I_LOAD,  10, 32'h10, 0, 0, 1, 0, 1, 36'h8DEADBEAA, 0, 0));
        tbl.push_back(mk(1, I_LOAD,  10, 32'h10, 0, 1, 1, 1, 1, 36'h8DEADBEAA, 0, 0));
        tbl.push_back(mk(1, I_LOAD,  11, 32'h10, 0, 1, 1, 1, 1, 36'h9DEADBEAA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'hADEADBEAA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'hBDEADBEAA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_OUTPUT, 0, 0, 32'h41, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h41));
        tbl.push_back(mk(1, I_LOAD,  15, 32'h10, 0, 1, 0, 0, 0, 0, 1, 8'h41));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h41));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h41));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 1, 8'h41));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_OUTPUT, 0, 0, 32'h42, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_OUTPUT, 0, 0, 32'h43, 1, 1, 1, 0, 0, 1, 8'h42));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 0, 0, 0, 0, 1, 8'h43));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 1, 8'h43));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_ADD,    0, 32'h10, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, I_LOAD,   2, 32'h10, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 1, 36'h2DEADBEAA, 0, 0));
        tbl.push_back(mk(0, I_NOP,    0, 0, 0, 1, 1, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].id, tbl[i].a, tbl[i].d, tbl[i].cr, tbl[i].orr);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), i_ready, tbl[i].er);
            chk($sformatf("vec%0d_cdb_valid", i), o_cdb_valid, tbl[i].ecv);
            if (tbl[i].ecv) chk($sformatf("vec%0d_cdb", i), o_cdb, tbl[i].ecdb);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].eov);
            if (tbl[i].eov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].eod);
            step();
        end

        // Asynchronous reset with two results queued; RAM must survive it.
        drive(1, I_STORE, 0, 32'h20, 32'h12345678, 1, 1); step();
        drive(1, I_LOAD, 1, 32'h20, 0, 0, 1); step();
        drive(1, I_LOAD, 2, 32'h20, 0, 0, 1); step();
        drive(0, I_NOP, 0, 0, 0, 0, 1); step();
        #2;
        chk("queued_cdb_valid", o_cdb_valid, 1);
        nrst = 1'b0;
        #1;
        chk("async_rst_cdb_valid", o_cdb_valid, 0);
        chk("async_rst_ready", i_ready, 0);
        @(negedge clk);
        #2 nrst = 1'b1;
        step();
        drive(1, I_LOAD, 4, 32'hABC00020, 0, 1, 1);
        @(negedge clk);
        chk("post_rst_cdb_valid0", o_cdb_valid, 0);
        step();
        drive(0, I_NOP, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("post_rst_cdb_valid1", o_cdb_valid, 0);
        step();
        @(negedge clk);
        chk("post_rst_cdb_valid2", o_cdb_valid, 1);
        chk("post_rst_cdb", o_cdb, 36'h412345678);
        step();
        step();
        chk("post_rst_drained", o_cdb_valid, 0);

        // Randomized traffic against a queue/array reference model.
        nrst = 1'b0;
        #1;
        do_reset();
        q.delete();
        m_ov = 1'b0;
        m_od = '0;
        n_ld = 0; n_st = 0; n_out = 0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            logic v, cr, orr, exp_cv, exp_ready, acc, pop;
            logic [5:0] op;
            logic [3:0] id;
            logic [31:0] a, d;
            int idx;
            idx = (cyc < 8) ? cyc : int'($urandom_range(0, 7));
            v   = (cyc < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
            op  = (cyc < 8) ? I_STORE : 6'($urandom_range(0, 14));
            id  = 4'($urandom);
            a   = ($urandom & 32'hFFFFFC00) | 32'(idx);
            d   = $urandom;
            cr  = $urandom_range(0, 3) != 0;
            orr = $urandom_range(0, 1) != 0;
            drive(v, op, id, a, d, cr, orr);
            @(negedge clk);
            exp_cv    = q.size() > 0 && q[0].at <= cyc;
            pop       = exp_cv && cr;
            exp_ready = !(m_ov && !orr) && (q.size() - int'(pop) < 2);
            chk("rnd_ready", i_ready, exp_ready);
            chk("rnd_cdb_valid", o_cdb_valid, exp_cv);
            if (exp_cv) chk("rnd_cdb", o_cdb, q[0].cdb);
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) chk("rnd_out_data", out_data, m_od);
            acc = v && exp_ready;
            if (pop) void'(q.pop_front());
            if (acc && op inside {I_STORE, I_STOREF, I_STORER, I_STORERF}) begin
                mram[a[9:0]] = d;
                n_st++;
            end else if (acc && op inside {I_STOREB, I_STOREBF}) begin
                mram[a[9:0]][7:0] = d[7:0];
                n_st++;
            end else if (acc && op inside {I_LOAD, I_LOADF, I_LOADR, I_LOADRF}) begin
                q.push_back('{{id, mram[a[9:0]]}, cyc + 2});
                n_ld++;
            end else if (acc && op inside {I_LOADB, I_LOADBF}) begin
                q.push_back('{{id, 24'h0, mram[a[9:0]][7:0]}, cyc + 2});
                n_ld++;
            end
            if (acc && op == I_OUTPUT) begin
                m_ov = 1'b1;
                m_od = d[7:0];
                n_out++;
            end else if (orr) begin
                m_ov = 1'b0;
            end
            step();
        end
`ifdef MRR_STATS_EN
        chk("stat_loads", o_load_count, 32'(n_ld));
        chk("stat_stores", o_store_count, 32'(n_st));
        chk("stat_outputs", o_output_count, 32'(n_out));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
